// File: rtl/imem_fetch.sv
// Instruction memory: valid/ready fetch port with fixed read latency, in-order responses,
// alignment/range fault reporting, and a byte-enabled program-load port.
module imem_fetch #(
  parameter int                  I_WIDTH     = 32,
  parameter int                  PC_WIDTH    = 32,
  parameter int                  DEPTH_WORDS = 1024,
  parameter logic [PC_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                  READ_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PC_WIDTH-1:0]  req_pc,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [I_WIDTH-1:0]   rsp_instr,
  output logic [PC_WIDTH-1:0]  rsp_pc,
  output logic [1:0]           rsp_fault,
  input  logic                 ld_en,
  input  logic [PC_WIDTH-1:0]  ld_addr,
  input  logic [I_WIDTH-1:0]   ld_data,
  input  logic [I_WIDTH/8-1:0] ld_be
);
  localparam int NB = I_WIDTH / 8;
  localparam int AW = $clog2(NB);
  localparam int MW = $clog2(DEPTH_WORDS);
  localparam int WW = PC_WIDTH - AW + 1;
  localparam int QD = READ_LAT + 1;
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);

  typedef struct packed {
    logic [I_WIDTH-1:0]  instr;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          fault;
    logic [1:0]          dly;
  } ent_t;

  logic [I_WIDTH-1:0] mem [DEPTH_WORDS];
  ent_t               q   [QD];
  ent_t               head, new_ent;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic               run, accept, pop;
  logic [WW-1:0]      req_widx, ld_widx;
  logic               req_mis, req_oor, ld_ok, ld_unused;

  // Word offsets carry one extra bit: an address below BASE_ADDR wraps to a value with the
  // top bit set, which then compares as out of range. BASE_ADDR is word aligned.
  assign req_widx  = {1'b0, req_pc[PC_WIDTH-1:AW]}  - {1'b0, BASE_ADDR[PC_WIDTH-1:AW]};
  assign ld_widx   = {1'b0, ld_addr[PC_WIDTH-1:AW]} - {1'b0, BASE_ADDR[PC_WIDTH-1:AW]};
  assign req_mis   = |req_pc[AW-1:0];
  assign req_oor   = req_widx >= WW'(DEPTH_WORDS);
  assign ld_ok     = ld_en && (ld_widx < WW'(DEPTH_WORDS));
  assign ld_unused = ^ld_addr[AW-1:0];

  always_comb begin
    new_ent       = '0;
    new_ent.pc    = req_pc;
    new_ent.dly   = 2'(READ_LAT - 1);
    if (req_mis)      new_ent.fault = 2'b01;
    else if (req_oor) new_ent.fault = 2'b10;
    else              new_ent.instr = mem[req_widx[MW-1:0]];
  end

  // The queue entry count covers both in-flight and waiting responses, so it doubles as credit.
  assign head      = q[rd_ptr];
  assign req_ready = run && !ld_en && (cnt < CW'(QD));
  assign rsp_valid = (cnt != '0) && (head.dly == 2'd0);
  assign rsp_instr = rsp_valid ? head.instr : '0;
  assign rsp_pc    = rsp_valid ? head.pc    : '0;
  assign rsp_fault = rsp_valid ? head.fault : 2'b00;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < QD; i++) q[i] <= '0;
    end else begin
      run <= 1'b1;
      for (int i = 0; i < QD; i++)
        if (q[i].dly != 2'd0) q[i].dly <= q[i].dly - 2'd1;
      if (accept) begin
        q[wr_ptr] <= new_ent;
        wr_ptr    <= (wr_ptr == PW'(QD - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(QD - 1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  // Array contents survive reset so a loaded program outlives a core reset.
  always_ff @(posedge clk) begin
    if (ld_ok)
      for (int b = 0; b < NB; b++)
        if (ld_be[b]) mem[ld_widx[MW-1:0]][8*b +: 8] <= ld_data[8*b +: 8];
  end
endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Parametrised instruction memory for the RISC-V core. It replaces the fixed, unhandshaked synchronous-read IM.
- Fetch port: valid/ready request/response with configurable read latency, in-order responses, alignment and range fault reporting.
- Byte-enabled program-load port used by the debug/boot loader to fill the array at run time.

Parameters:
- I_WIDTH, 32, instruction/word width in bits (multiple of 8).
- PC_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, number of words in the array (power of 2).
- BASE_ADDR, 0, byte address of word 0.
- READ_LAT, 1, cycles from request acceptance to response valid (1 or 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted.
- req_pc  in  PC_WIDTH  fetch byte address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_instr  out  I_WIDTH  fetched word (0 on fault).
- rsp_pc  out  PC_WIDTH  req_pc of this response.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out-of-range.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  PC_WIDTH  load byte address (word-aligned; low bits ignored).
- ld_data  in  I_WIDTH  load data.
- ld_be  in  I_WIDTH/8  byte enables; bit k writes ld_data[8k+7:8k].

Behaviour:
- Reset (async assert, sync deassert expected upstream): req_ready=0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=00. All in-flight and buffered responses are discarded. The memory array is NOT cleared.
- Accept: a request is accepted on an edge where req_valid && req_ready. The response for it presents rsp_valid=1 exactly READ_LAT cycles later when no responses are queued ahead of it. Responses are strictly in acceptance order.
- Response hold: rsp_valid, rsp_instr, rsp_pc and rsp_fault stay stable until the edge where rsp_valid && rsp_ready. Responses are never dropped.
- Buffering: the internal response queue has depth READ_LAT+1. req_ready = !ld_en && (in_flight + queued < READ_LAT+1). req_ready is registered or combinational from state only; it must not depend combinationally on req_valid. Sustained throughput is 1 request/cycle when rsp_ready is held 1.
- Index: word index = (req_pc - BASE_ADDR) >> log2(I_WIDTH/8).
- Misaligned: the low log2(I_WIDTH/8) bits of req_pc are nonzero. Reported as fault=01.
- Out-of-range: req_pc < BASE_ADDR, or index >= DEPTH_WORDS. Reported as fault=10.
- Fault precedence: misaligned is reported over out-of-range.
- Faulted requests: accepted normally, same latency and ordering, rsp_instr=0, array not read.
- Load writes: on an edge with ld_en=1 and ld_addr in range, bytes with ld_be=1 are written; other bytes are unchanged. Out-of-range writes are silently dropped.
- Load vs. fetch: while ld_en=1, req_ready=0, so a write and an accept never share an edge. A fetch accepted before a write to the same word returns the pre-write data. A fetch accepted after it returns the new data.
- Backpressure with ld_en: ld_en=1 does not stall responses already in flight.
- Wrap-around: req_pc - BASE_ADDR is computed in PC_WIDTH+1 bits so underflow is detected. There is no wrap into the array.

Test Plan:
- Reset, load words 0x00000013 @0x0, 0x00100093 @0x4, then fetch 0x0, 0x4 back-to-back with rsp_ready=1 -> rsp 0x00000013/pc 0x0 then 0x00100093/pc 0x4 on consecutive cycles, READ_LAT after each accept, fault=00.
- Fetch 0x2 then 0x1000 (DEPTH_WORDS=1024) then 0x8 -> fault 01, then 10, both rsp_instr=0, then the valid word for 0x8; order preserved.
- rsp_ready=0 for 6 cycles with req_valid=1 -> exactly READ_LAT+1 accepts, then req_ready=0. Release -> all responses drain in order with no loss or duplication.
- Word 0x8 = 0xAABBCCDD, ld_be=0b0101 with ld_data 0x11223344 -> fetch 0x8 returns 0xAA22CC44. ld_en=1 holds req_ready=0 that cycle.
- Fetch 0xC accepted, next cycle load 0xC = 0xDEADBEEF, fetch 0xC again -> old data first, then 0xDEADBEEF.
- Assert rst_n=0 mid-stream with 2 responses queued -> rsp_valid drops immediately. After release, no stale response appears and previously loaded contents still read back.
